// File: rtl/key_sequence_sender_if.sv
// Key sequence sender bus: start/unlock toward the sender, key pulses and status back.
interface key_sequence_sender_if;
  logic       start;
  logic       unlock;
  logic [3:0] keys;
  logic       busy;
  logic [3:0] progress;
  logic       done;
  logic       pass;

  modport master (
    input  start,
    input  unlock,
    output keys,
    output busy,
    output progress,
    output done,
    output pass
  );

  modport slave (
    output start,
    output unlock,
    input  keys,
    input  busy,
    input  progress,
    input  done,
    input  pass
  );
endinterface

// File: rtl/key_sequence_sender.sv
// Sends a four-key one-hot sequence with idle gaps, then checks for unlock.
// Optional: KEY_SEQUENCE_SENDER_UNLOCK_CHECK_EN enables the WAIT_UNLOCK phase.
module key_sequence_sender #(
  parameter logic [3:0] CODE0   = 4'b0001,
  parameter logic [3:0] CODE1   = 4'b0100,
  parameter logic [3:0] CODE2   = 4'b1000,
  parameter logic [3:0] CODE3   = 4'b0010,
  parameter int         GAP     = 3,
  parameter int         TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset,
  key_sequence_sender_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_GAP,
`ifdef KEY_SEQUENCE_SENDER_UNLOCK_CHECK_EN
    S_WAIT,
`endif
    S_FINISH
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

`ifdef KEY_SEQUENCE_SENDER_UNLOCK_CHECK_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
`else
  // Without the unlock check, TIMEOUT and unlock have no function.
  logic unused_cfg;
  assign unused_cfg = ^{bus.unlock, 8'(TIMEOUT)};
`endif

  state_t     state, state_d;
  logic [1:0] idx, idx_d;
  logic [7:0] cnt, cnt_d;
  logic [3:0] keys_q, keys_d;
  logic [3:0] prog_q, prog_d;
  logic       pass_q, pass_d;

  function automatic logic [3:0] code_of(input logic [1:0] i);
    logic [3:0] c;
    unique case (i)
      2'd0:    c = CODE0;
      2'd1:    c = CODE1;
      2'd2:    c = CODE2;
      default: c = CODE3;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      cnt    <= 8'd0;
      keys_q <= 4'b0;
      prog_q <= 4'b0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      cnt    <= cnt_d;
      keys_q <= keys_d;
      prog_q <= prog_d;
      pass_q <= pass_d;
    end
  end

  // keys_d is loaded one cycle ahead so the registered pulse lands in KEY.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    keys_d  = 4'b0;
    prog_d  = prog_q;
    pass_d  = pass_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_KEY;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          keys_d  = CODE0;
          prog_d  = 4'b0;
          pass_d  = 1'b0;
        end
      end
      S_KEY: begin
        prog_d[idx] = 1'b1;
        state_d     = S_GAP;
        cnt_d       = 8'd0;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d = 8'd0;
          if (idx != 2'd3) begin
            state_d = S_KEY;
            idx_d   = idx + 2'd1;
            keys_d  = code_of(idx + 2'd1);
          end else begin
`ifdef KEY_SEQUENCE_SENDER_UNLOCK_CHECK_EN
            state_d = S_WAIT;
`else
            state_d = S_FINISH;
            pass_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
`ifdef KEY_SEQUENCE_SENDER_UNLOCK_CHECK_EN
      S_WAIT: begin
        if (bus.unlock) begin
          state_d = S_FINISH;
          pass_d  = 1'b1;
          cnt_d   = 8'd0;
        end else if (cnt == TO_LAST) begin
          state_d = S_FINISH;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
`endif
      S_FINISH: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        idx_d   = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        idx_d   = 2'd0;
      end
    endcase
  end

  assign bus.keys     = keys_q;
  assign bus.progress = prog_q;
  assign bus.pass     = pass_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_FINISH);

endmodule
